instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction-fetch and next-PC sequencer for the multi-cycle MIPS CPU. Holds the program counter, fetches words from instruction memory over a req/ack handshake, and presents the current instruction's opcode/funct/fields to the control unit. It consumes the control unit's jump/jal/jr/branch decisions back to select the next PC. This is the producing end of the opcode/funct interface and the consuming end of the flow-control outputs.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word-aligned)
- TIMEOUT_CYCLES, 16, fetch watchdog limit (used only with FETCH_TIMEOUT_EN)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request, held until ack
- imem_addr  out  32  fetch address (= pc), stable while imem_req=1
- imem_ack  in  1  read data valid this cycle
- imem_rdata  in  32  instruction word
- instr_valid  out  1  current instruction is held for execution
- opcode  out  6  instr[31:26]
- funct  out  6  instr[5:0]
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11]
- imm  out  16  instr[15:0]
- pc_plus4  out  32  pc+4 of held instruction (jal link value)
- exec_done  in  1  datapath finished held instruction; commit next PC
- jump, jal, jr, branch  in  1 each  control-unit flow decisions
- jr_target  in  32  register value for jr
- halt  in  1  stop after current instruction
- misalign  out  1  sticky: jr target had nonzero [1:0]
- fetch_err  out  1  sticky fetch timeout (tied 0 without macro)

## Operation
- States: IDLE, FETCH, EXEC, HALTED (plus ERR with macro).
- IDLE: entered on reset; unconditionally to FETCH next cycle.
- FETCH: imem_req=1, imem_addr=pc. On imem_ack: latch imem_rdata into instruction register, go EXEC.
- EXEC: instr_valid=1; fields driven combinationally from instruction register. On exec_done: load next PC; go HALTED if halt=1, else FETCH.
- HALTED: imem_req=0, instr_valid=0; go FETCH when halt=0.
- Next-PC priority (evaluated at exec_done): jr -> {jr_target[31:2],2'b00}; else jump or jal -> {pc_plus4[31:28], instr[25:0], 2'b00}; else branch -> pc_plus4 + (sign_ext(imm) << 2); else pc_plus4. All adds modulo 2^32.
- misalign set when jr selected with jr_target[1:0]!=0; cleared only by reset.
- imem_ack ignored outside FETCH; exec_done ignored outside EXEC; halt ignored in FETCH (no request abandonment).
- Reset values: pc=RESET_PC, instruction register=0, imem_req=0, imem_addr=RESET_PC, instr_valid=0, all fields 0, pc_plus4=RESET_PC+4, misalign=0, fetch_err=0.
- Reset mid-fetch or mid-exec: state returns to IDLE immediately; in-flight ack lost.

## Timing
- Reset release -> imem_req=1 at cycle 1 (IDLE lasts one cycle).
- Ack in cycle N -> instr_valid=1 in cycle N+1.
- exec_done in cycle M -> new pc and imem_req=1 in cycle M+1.
- Minimum throughput: 2 cycles per instruction (same-cycle ack and exec_done).
- imem_addr never changes while imem_req=1 and ack not yet seen.

## Configuration
- FETCH_TIMEOUT_EN defined: counter increments each FETCH cycle without ack, clears on ack/leaving FETCH; reaching TIMEOUT_CYCLES sets fetch_err (sticky), drops imem_req, enters ERR; ERR exits only by reset.
- Undefined: no counter, FETCH waits indefinitely, fetch_err constant 0, ERR absent.

## Test plan
- Reset: rst_n low mid-FETCH -> imem_req=0, pc=0; release -> imem_req=1, imem_addr=0 one cycle later.
- Sequential: ack every request, exec_done immediately, no flow signals -> addresses 0x0,0x4,0x8, instr_valid each alternate cycle.
- Jump: pc=0x1000_0010, instr=0x0800_0040, jump=1 -> next imem_addr=0x1000_0100.
- Branch: pc=0x20, imm=16'hFFFE, branch=1 -> next imem_addr=0x1C; same with branch=0 -> 0x24.
- jr priority and misalign: jr=1, jump=1, jr_target=0x0000_0203 -> next addr 0x200, misalign=1 persists across later instructions.
- Timeout (macro on, TIMEOUT_CYCLES=16): withhold ack -> fetch_err=1 and imem_req=0 after 16 FETCH cycles; late ack ignored.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch / next-PC sequencer for the multi-cycle MIPS core.
// Optional fetch watchdog is enabled by defining FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [31:0] pc_plus4,
  input  logic        exec_done,
  input  logic        jump,
  input  logic        jal,
  input  logic        jr,
  input  logic        branch,
  input  logic [31:0] jr_target,
  input  logic        halt,
  output logic        misalign,
  output logic        fetch_err
);

  typedef enum logic [2:0] {
    IDLE, FETCH, EXEC, HALTED
`ifdef FETCH_TIMEOUT_EN
    , ERR
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        misalign_q, misalign_d;
  logic [31:0] pc4, br_off, npc;

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};

  // jr outranks jump/jal, which outrank branch
  always_comb begin
    if (jr)                npc = {jr_target[31:2], 2'b00};
    else if (jump || jal)  npc = {pc4[31:28], ir_q[25:0], 2'b00};
    else if (branch)       npc = pc4 + br_off;
    else                   npc = pc4;
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  logic          ferr_q, ferr_d;

  assign tmo_hit = (state_q == FETCH) && !imem_ack && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    tmo_d  = '0;
    ferr_d = ferr_q;
    if (state_q == FETCH && !imem_ack) tmo_d = tmo_q + 1'b1;
    if (tmo_hit) ferr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q  <= '0;
      ferr_q <= 1'b0;
    end else begin
      tmo_q  <= tmo_d;
      ferr_q <= ferr_d;
    end
  end

  assign fetch_err = ferr_q;
`else
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      misalign_q <= misalign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   state_d = FETCH;
      FETCH: begin
        if (imem_ack) state_d = EXEC;
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) state_d = ERR;
`endif
      end
      EXEC:   if (exec_done) state_d = halt ? HALTED : FETCH;
      HALTED: if (!halt) state_d = FETCH;
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    ir_d       = ir_q;
    misalign_d = misalign_q;
    if (state_q == FETCH && imem_ack) ir_d = imem_rdata;
    if (state_q == EXEC && exec_done) begin
      pc_d = npc;
      if (jr && jr_target[1:0] != 2'b00) misalign_d = 1'b1;
    end
  end

  always_comb begin
    imem_req    = (state_q == FETCH);
    instr_valid = (state_q == EXEC);
  end

  assign imem_addr = pc_q;
  assign pc_plus4  = pc4;
  assign misalign  = misalign_q;
  assign opcode    = ir_q[31:26];
  assign rs        = ir_q[25:21];
  assign rt        = ir_q[20:16];
  assign rd        = ir_q[15:11];
  assign imm       = ir_q[15:0];
  assign funct     = ir_q[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: expected fetch addresses are queued
// as each instruction is executed and checked when the next request appears.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ack, instr_valid, exec_done;
  logic [31:0] imem_addr, imem_rdata, pc_plus4, jr_target;
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd;
  logic [15:0] imm;
  logic        jump, jal, jr, branch, halt, misalign, fetch_err;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .opcode(opcode), .funct(funct), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .pc_plus4(pc_plus4), .exec_done(exec_done), .jump(jump), .jal(jal),
    .jr(jr), .branch(branch), .jr_target(jr_target), .halt(halt),
    .misalign(misalign), .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(output logic [31:0] exp);
    int n = 0;
    while (imem_req !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    check("valid_low_in_fetch", {31'b0, instr_valid}, 32'd0);
    if (sb.size() == 0) begin
      check("sb_nonempty", 32'd0, 32'd1);
      exp = 32'hx;
    end else begin
      exp = sb.pop_front();
      check("imem_addr", imem_addr, exp);
    end
  endtask

  // Fetch one instruction with same-cycle ack, then execute it with the given flow flags.
  task automatic fe(input logic [31:0] ins, input logic j, input logic jl, input logic r,
                    input logic b, input logic [31:0] jt, input logic h);
    logic [31:0] exp;
    wait_req(exp);
    imem_ack = 1'b1; imem_rdata = ins;
    @(negedge clk);
    imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
    check("instr_valid", {31'b0, instr_valid}, 32'd1);
    check("fields", {opcode, rs, rt, imm}, ins);
    check("funct_rd", {21'b0, rd, funct}, {21'b0, ins[15:11], ins[5:0]});
    check("pc_plus4", pc_plus4, exp + 32'd4);
    exec_done = 1'b1; jump = j; jal = jl; jr = r; branch = b; jr_target = jt; halt = h;
    @(negedge clk);
    exec_done = 1'b0; jump = 1'b0; jal = 1'b0; jr = 1'b0; branch = 1'b0; jr_target = '0;
  endtask

  localparam logic [31:0] ADD = 32'h012A_4020;
  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] BEQ = 32'h1000_FFFE;

  initial begin
    logic [31:0] e;
    rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = '0; exec_done = 1'b0;
    jump = 1'b0; jal = 1'b0; jr = 1'b0; branch = 1'b0; jr_target = '0; halt = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_req", {31'b0, imem_req}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_pc4", pc_plus4, 32'h4);
    check("rst_fields", {opcode, rs, rt, imm}, 32'h0);
    check("rst_flags", {30'b0, misalign, fetch_err}, 32'd0);
    rst_n = 1'b1;
    #1 check("idle_req", {31'b0, imem_req}, 32'd0);
    @(negedge clk);
    check("first_req", {31'b0, imem_req}, 32'd1);
    @(negedge clk);
    // reset in the middle of a fetch
    rst_n = 1'b0;
    #1 check("midrst_req", {31'b0, imem_req}, 32'd0);
    check("midrst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rerel_req", {31'b0, imem_req}, 32'd1);

    sb.push_back(32'h0);          fe(ADD, 0, 0, 0, 0, 0, 0);
    sb.push_back(32'h4);          fe(NOP, 0, 0, 0, 0, 0, 0);
    sb.push_back(32'h8);          fe(NOP, 0, 0, 1, 0, 32'h1000_0010, 0);
    sb.push_back(32'h1000_0010);  fe(32'h0800_0040, 1, 0, 0, 0, 0, 0);
    sb.push_back(32'h1000_0100);  fe(NOP, 0, 0, 1, 0, 32'h0000_0020, 0);
    sb.push_back(32'h20);         fe(BEQ, 0, 0, 0, 1, 0, 0);
    sb.push_back(32'h1C);         fe(NOP, 0, 1, 1, 0, 32'h0000_0020, 0);
    sb.push_back(32'h20);         fe(BEQ, 0, 0, 0, 0, 0, 0);
    check("misalign_clear", {31'b0, misalign}, 32'd0);
    sb.push_back(32'h24);         fe(NOP, 1, 0, 1, 0, 32'h0000_0203, 0);
    check("misalign_set", {31'b0, misalign}, 32'd1);
    sb.push_back(32'h200);        fe(ADD, 0, 0, 0, 0, 0, 1);
    // halted: no request, stray ack must not load the instruction register
    check("halt_req", {31'b0, imem_req}, 32'd0);
    check("halt_valid", {31'b0, instr_valid}, 32'd0);
    imem_ack = 1'b1; imem_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    imem_ack = 1'b0;
    check("halt_ir_kept", {opcode, rs, rt, imm}, ADD);
    check("halt_req2", {31'b0, imem_req}, 32'd0);
    halt = 1'b0;
    sb.push_back(32'h204);        fe(NOP, 0, 0, 0, 0, 0, 0);
    check("misalign_sticky", {31'b0, misalign}, 32'd1);
    sb.push_back(32'h208);
    wait_req(e);
`ifdef FETCH_TIMEOUT_EN
    repeat (15) @(negedge clk);
    check("tmo_req_still", {31'b0, imem_req}, 32'd1);
    check("tmo_err_low", {31'b0, fetch_err}, 32'd0);
    @(negedge clk);
    check("tmo_req_drop", {31'b0, imem_req}, 32'd0);
    check("tmo_err", {31'b0, fetch_err}, 32'd1);
    imem_ack = 1'b1; imem_rdata = ADD;
    @(negedge clk);
    imem_ack = 1'b0;
    check("tmo_late_ack", {30'b0, instr_valid, imem_req}, 32'd0);
`else
    repeat (20) @(negedge clk);
    check("wait_req_held", {31'b0, imem_req}, 32'd1);
    check("wait_addr_held", imem_addr, 32'h208);
    check("no_fetch_err", {31'b0, fetch_err}, 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
